// File: rtl/mux_scan_pkg.sv
// Shared types and constants for mux_sel_scanner.
// Holds the FSM state type, channel count/select width, and a helper that finds the
// lowest enabled channel at or above a given index.
package mux_scan_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned SEL_W  = 2;

  typedef enum logic [1:0] {
    StIdle,
    StDwell,
    StDone
  } scan_state_e;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } ch_pick_t;

  // Lowest set bit of mask with index >= from; found=0 when none remains.
  function automatic ch_pick_t pick_ch(logic [NUM_CH-1:0] mask, int from);
    ch_pick_t res;
    res = '{found: 1'b0, idx: '0};
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (i >= from && mask[i]) begin
        res.found = 1'b1;
        res.idx   = SEL_W'(i);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mux_sel_scanner_if.sv
// Signal bundle between mux_sel_scanner and its surroundings.
// master: drives start/continuous (controller) and out (mux return path), reads results.
// slave:  the scanner itself.
// ch_mask exists only when SCAN_MASK_EN is defined.
interface mux_sel_scanner_if;
  import mux_scan_pkg::*;

  logic              start;
  logic              continuous;
  logic              out;
`ifdef SCAN_MASK_EN
  logic [NUM_CH-1:0] ch_mask;
`endif
  logic              s1;
  logic              s0;
  logic [NUM_CH-1:0] sample;
  logic              valid;
  logic              busy;

`ifdef SCAN_MASK_EN
  modport master (
    output start, continuous, out, ch_mask,
    input  s1, s0, sample, valid, busy
  );
  modport slave (
    input  start, continuous, out, ch_mask,
    output s1, s0, sample, valid, busy
  );
`else
  modport master (
    output start, continuous, out,
    input  s1, s0, sample, valid, busy
  );
  modport slave (
    input  start, continuous, out,
    output s1, s0, sample, valid, busy
  );
`endif

endinterface

// File: rtl/scan_dwell_timer.sv
// Dwell counter for mux_sel_scanner.
// Ports: clk, rst_n (async active-low), clr_i (sync clear), en_i (count enable),
//        tc_o (high while enabled on the last dwell cycle; counter wraps to 0 there).
// With DWELL=1 there is no counter and tc_o simply follows en_i.
module scan_dwell_timer #(
  parameter int unsigned DWELL = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  if (DWELL <= 1) begin : g_pass
    logic unused_ok;
    assign unused_ok = ^{clk, rst_n, clr_i};
    assign tc_o      = en_i;
  end else begin : g_cnt
    localparam int unsigned CntW = $clog2(DWELL);
    localparam logic [CntW-1:0] LastCnt = CntW'(DWELL - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tc_o = en_i && (cnt_q == LastCnt);

    always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
        cnt_d = '0;
      end else if (en_i) begin
        cnt_d = tc_o ? '0 : cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end
  end

endmodule

// File: rtl/mux_sel_scanner.sv
// Select-line sequencer for a downstream 4:1 mux.
// On start, steps {s1,s0} over the enabled channels, holding each for DWELL cycles and
// capturing the mux return (out) on the last dwell cycle; then publishes all captured bits
// as sample with a one-cycle valid in a single DONE cycle.
// Ports: clk, rst_n (async active-low), bus (mux_sel_scanner_if.slave: start, continuous,
//        out, [ch_mask] in; s1, s0, sample, valid, busy out). All outputs are registered.
// Build option: SCAN_MASK_EN adds ch_mask, latched on leaving IDLE; disabled channels are
// skipped entirely. Without it all four channels are always scanned.
module mux_sel_scanner
  import mux_scan_pkg::*;
#(
  parameter int unsigned DWELL = 4
) (
  input logic               clk,
  input logic               rst_n,
  mux_sel_scanner_if.slave  bus
);

  if (DWELL < 1) begin : g_bad_dwell
    $fatal(1, "mux_sel_scanner: DWELL must be >= 1");
  end

  scan_state_e       state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [NUM_CH-1:0] shadow_q, shadow_d;
  logic [NUM_CH-1:0] sample_q, sample_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic [NUM_CH-1:0] idle_mask, scan_mask;
  logic [NUM_CH-1:0] captured;
  logic              dwell_tc;
  ch_pick_t          first_idle, first_scan, next_scan;

`ifdef SCAN_MASK_EN
  logic [NUM_CH-1:0] mask_q, mask_d;
  assign idle_mask = bus.ch_mask;
  assign scan_mask = mask_q;
`else
  assign idle_mask = '1;
  assign scan_mask = '1;
`endif

  scan_dwell_timer #(
    .DWELL (DWELL)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (state_q != StDwell),
    .en_i  (state_q == StDwell),
    .tc_o  (dwell_tc)
  );

  assign first_idle = pick_ch(idle_mask, 0);
  assign first_scan = pick_ch(scan_mask, 0);
  assign next_scan  = pick_ch(scan_mask, int'(sel_q) + 1);

  always_comb begin
    captured        = shadow_q;
    captured[sel_q] = bus.out;
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    shadow_d = shadow_q;
    sample_d = sample_q;
    valid_d  = 1'b0;
`ifdef SCAN_MASK_EN
    mask_d   = mask_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
`ifdef SCAN_MASK_EN
          mask_d = bus.ch_mask;
`endif
          if (first_idle.found) begin
            state_d = StDwell;
            sel_d   = first_idle.idx;
          end else begin
            // Empty mask: publish an all-zero word right away.
            state_d  = StDone;
            valid_d  = 1'b1;
            sample_d = '0;
            shadow_d = '0;
          end
        end
      end
      StDwell: begin
        if (dwell_tc) begin
          if (next_scan.found) begin
            sel_d    = next_scan.idx;
            shadow_d = captured;
          end else begin
            // Publish on entry so sample and valid appear together during DONE.
            state_d  = StDone;
            sel_d    = '0;
            valid_d  = 1'b1;
            sample_d = captured;
            shadow_d = '0;
          end
        end
      end
      StDone: begin
        if (bus.continuous && first_scan.found) begin
          state_d = StDwell;
          sel_d   = first_scan.idx;
        end else if (bus.continuous) begin
          valid_d  = 1'b1;
          sample_d = '0;
          shadow_d = '0;
        end else begin
          state_d = StIdle;
          sel_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      sel_q    <= '0;
      shadow_q <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
`ifdef SCAN_MASK_EN
      mask_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      shadow_q <= shadow_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
`ifdef SCAN_MASK_EN
      mask_q   <= mask_d;
`endif
    end
  end

  assign bus.s1     = sel_q[1];
  assign bus.s0     = sel_q[0];
  assign bus.sample = sample_q;
  assign bus.valid  = valid_q;
  assign bus.busy   = busy_q;

endmodule

// File: doc/mux_sel_scanner.md
# mux_sel_scanner

Sequencer that sits directly upstream of `mux_4_1` and drives its select lines. It also consumes the mux output on the return path. On `start` it steps `{s1,s0}` through channels 0..3, holds each select for a programmable dwell time, and captures `out` on the last dwell cycle of each channel. It then publishes all four captured bits together as one coherent `sample` word with a one-cycle `valid` strobe.

## Interface
Parameters:
- `DWELL`, default 4: cycles each select value is held. Must be ≥1; a value <1 is an elaboration error.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  level, sampled only in IDLE; high starts a scan.
- `continuous`  in  1  when high, the next scan starts automatically after DONE.
- `out`  in  1  `mux_4_1` output.
- `ch_mask`  in  4  channel enable; bit i=1 scans channel i. Present only with `SCAN_MASK_EN`.
- `s1`  out  1  select MSB to the mux.
- `s0`  out  1  select LSB to the mux.
- `sample`  out  4  captured word; bit i = value of `out` while channel i was selected.
- `valid`  out  1  one-cycle strobe when `sample` updates.
- `busy`  out  1  high from the first DWELL cycle through DONE.

## Operation
- The FSM has three states.
  - IDLE: `{s1,s0}`=00, `busy`=0. If `start`=1, go to DWELL at the first enabled channel with dwell count 0.
  - DWELL: hold select and increment the dwell count. When count==`DWELL`-1:
    - write `out` into shadow bit [sel];
    - if sel is the last enabled channel, go to DONE; otherwise advance to the next enabled channel and clear the count.
  - DONE (one cycle):
    - `sample` <= shadow, `valid`=1, `{s1,s0}`=00, shadow cleared.
    - Next state is DWELL at the first enabled channel if `continuous`=1, else IDLE.
- `start` is ignored in DWELL and DONE.
- If `start` is still high on return to IDLE, a new scan begins on the next cycle.
- `sample` holds its value between DONE cycles. Bits for unscanned channels read 0.
- Reset (asserted any time, including mid-scan) immediately forces:
  - `{s1,s0}`=00, `sample`=0, `valid`=0, `busy`=0, shadow=0, state IDLE, dwell count 0.
  - A scan interrupted by reset produces no `valid`.

## Timing
- `start` is sampled at the edge ending cycle 0. DWELL runs cycles 1..4·`DWELL`, DONE is cycle 4·`DWELL`+1, IDLE follows.
- Start-to-`valid` latency is 4·`DWELL`+1 cycles.
- In continuous mode the scan period is 4·`DWELL`+1 cycles, with one DONE cycle at select 00 between scans.
- `s1`, `s0`, `valid`, `busy` and `sample` are all registered outputs with no combinational path from inputs.
- `out` is captured at the rising edge ending the last dwell cycle. The mux path must settle within `DWELL` cycles.

## Configuration
- `SCAN_MASK_EN` defined:
  - The `ch_mask` port exists and is latched on leaving IDLE; mid-scan changes to it are ignored.
  - Disabled channels are skipped with zero cycles spent on them.
  - Mask 0000: go IDLE→DONE directly, so `valid` is high the cycle after `start` with `sample`=0000.
  - Latency is N·`DWELL`+1 cycles for N enabled channels.
- `SCAN_MASK_EN` undefined: the `ch_mask` port is absent and all four channels are always scanned.

## Structure
- Package `mux_scan_pkg`: state enum typedef (`IDLE`, `DWELL`, `DONE`), `NUM_CH`=4, `SEL_W`=2.
- One natural sub-module, `scan_dwell_timer`:
  - `$clog2(DWELL)`-bit counter with clear and enable inputs and a terminal-count output.
  - Pass-through when `DWELL`=1.
- `mux_4_1` is not instantiated inside this block; the two are connected at the parent level.

## Test plan
- Reset: `rst_n`=0 mid-operation → `s1`,`s0`,`valid`,`busy`=0 and `sample`=0000 immediately, without waiting for a clock edge.
- Single scan, `DWELL`=4, mux inputs i0..i3=1,0,1,0, `start` pulse in cycle 0:
  - select 00/01/10/11 on cycles 1-4/5-8/9-12/13-16;
  - `valid` only in cycle 17 with `sample`=0101;
  - `busy` high on cycles 1-17.
- Continuous=1, same inputs, i3 changed to 1 at cycle 20 → `valid` at cycles 17 and 34 with `sample` 0101 then 1101.
- `start` pulse again at cycle 8 during the first scan → ignored; exactly one `valid`, at cycle 17.
- `rst_n` pulsed low at cycle 10, then `start` at cycle 20 → no `valid` before cycle 37; `sample`=0101 at cycle 37.
- With `SCAN_MASK_EN`, `ch_mask`=1010, inputs 1,1,1,0:
  - only selects 01 and 11 visited (cycles 1-4, 5-8);
  - `valid` at cycle 9 with `sample`=0010.
